// File: rtl/game_frame_ctrl.sv
// Frame-sequencing controller: per frame it strobes a datapath update, checks for
// game over, draws every object through the shared plotter, waits one frame period
// (freezable by pause), then erases every object and counts the completed frame.
//
// Ports:
//   clock        system clock, all logic on rising edge
//   reset        synchronous active-high reset
//   start        level start button (synchronised)
//   pause        level pause request, honoured only while waiting between frames
//   finish_game  datapath game-over flag, sampled only in CHECK
//   plot_done    one-cycle plotter completion pulse
//   update       one-cycle datapath update strobe
//   plot_req     plotter request for object obj_sel
//   draw         paint object colour (with plot_req)
//   erase        paint background (with plot_req)
//   obj_sel      index of the object being plotted
//   paused       frame counter was frozen by pause on the last edge
//   game_over    high in END
//   frames_done  completed-frame count, wraps
module game_frame_ctrl #(
    parameter int unsigned NUM_OBJ     = 4,
    parameter int unsigned OBJ_W       = 2,
    parameter int unsigned FRAME_TICKS = 833333,
    parameter int unsigned TICK_W      = 20,
    parameter int unsigned FCNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              finish_game,
    input  logic              plot_done,
    output logic              update,
    output logic              plot_req,
    output logic              draw,
    output logic              erase,
    output logic [OBJ_W-1:0]  obj_sel,
    output logic              paused,
    output logic              game_over,
    output logic [FCNT_W-1:0] frames_done
);

    localparam logic [OBJ_W-1:0]  LAST_OBJ  = OBJ_W'(NUM_OBJ - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(FRAME_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_UPDATE = 3'd2,
        S_CHECK  = 3'd3,
        S_DRAW   = 3'd4,
        S_WAIT   = 3'd5,
        S_ERASE  = 3'd6,
        S_END    = 3'd7
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [OBJ_W-1:0]    obj_nxt;
    logic [TICK_W-1:0]   tick;
    logic [TICK_W-1:0]   tick_nxt;
    logic [FCNT_W-1:0]   frames_nxt;
    logic                update_nxt;
    logic                plot_req_nxt;
    logic                draw_nxt;
    logic                erase_nxt;
    logic                paused_nxt;
    logic                game_over_nxt;

    // State, counters and registered outputs; reset wins over any same-cycle plot_done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            obj_sel     <= '0;
            tick        <= '0;
            frames_done <= '0;
            update      <= 1'b0;
            plot_req    <= 1'b0;
            draw        <= 1'b0;
            erase       <= 1'b0;
            paused      <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nxt;
            obj_sel     <= obj_nxt;
            tick        <= tick_nxt;
            frames_done <= frames_nxt;
            update      <= update_nxt;
            plot_req    <= plot_req_nxt;
            draw        <= draw_nxt;
            erase       <= erase_nxt;
            paused      <= paused_nxt;
            game_over   <= game_over_nxt;
        end
    end

    // Next state and counters; outputs are decoded from the next state so the
    // registered copies line up with the state they belong to.
    always_comb begin
        state_nxt  = state;
        obj_nxt    = obj_sel;
        tick_nxt   = tick;
        frames_nxt = frames_done;
        paused_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ARM;
            end
            S_ARM: begin
                // wait for the button to be released before starting a frame
                if (!start) state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (finish_game) begin
                    state_nxt = S_END;
                end else begin
                    state_nxt = S_DRAW;
                    obj_nxt   = '0;
                end
            end
            S_DRAW: begin
                if (plot_done) begin
                    if (obj_sel == LAST_OBJ) begin
                        obj_nxt   = '0;
                        tick_nxt  = '0;
                        state_nxt = S_WAIT;
                    end else begin
                        obj_nxt = obj_sel + OBJ_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (pause) begin
                    paused_nxt = 1'b1;
                end else if (tick == LAST_TICK) begin
                    state_nxt = S_ERASE;
                    obj_nxt   = '0;
                end else begin
                    tick_nxt = tick + TICK_W'(1);
                end
            end
            S_ERASE: begin
                if (plot_done) begin
                    if (obj_sel == LAST_OBJ) begin
                        obj_nxt    = '0;
                        frames_nxt = frames_done + FCNT_W'(1);
                        state_nxt  = S_UPDATE;
                    end else begin
                        obj_nxt = obj_sel + OBJ_W'(1);
                    end
                end
            end
            S_END: begin
                if (start) begin
                    state_nxt  = S_ARM;
                    frames_nxt = '0;
                    obj_nxt    = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        update_nxt    = (state_nxt == S_UPDATE);
        draw_nxt      = (state_nxt == S_DRAW);
        erase_nxt     = (state_nxt == S_ERASE);
        plot_req_nxt  = draw_nxt || erase_nxt;
        game_over_nxt = (state_nxt == S_END);
    end

endmodule

// File: tb/tb_game_frame_ctrl.sv
// Self-checking bench for game_frame_ctrl: a phase-level reference model is
// compared against every DUT output each cycle, a plotter responder answers
// requests, and directed frames pin exact timings with literal expectations.
module tb_game_frame_ctrl;

    localparam int unsigned NUM_OBJ     = 4;
    localparam int unsigned OBJ_W       = 2;
    localparam int unsigned FRAME_TICKS = 8;
    localparam int unsigned TICK_W      = 3;
    localparam int unsigned FCNT_W      = 2;

    localparam int P_IDLE = 0, P_ARM = 1, P_UPD = 2, P_CHK = 3,
                   P_DRAW = 4, P_WAIT = 5, P_ERASE = 6, P_END = 7;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              finish_game = 1'b0;
    logic              plot_done = 1'b0;
    logic              update, plot_req, draw, erase, paused, game_over;
    logic [OBJ_W-1:0]  obj_sel;
    logic [FCNT_W-1:0] frames_done;
    logic [9:0]        out_vec;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int lat_fixed = 3;
    bit stray_en = 1'b0;

    game_frame_ctrl #(
        .NUM_OBJ(NUM_OBJ), .OBJ_W(OBJ_W), .FRAME_TICKS(FRAME_TICKS),
        .TICK_W(TICK_W), .FCNT_W(FCNT_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .finish_game(finish_game), .plot_done(plot_done),
        .update(update), .plot_req(plot_req), .draw(draw), .erase(erase),
        .obj_sel(obj_sel), .paused(paused), .game_over(game_over),
        .frames_done(frames_done)
    );

    always #5 clock = ~clock;

    assign out_vec = {update, plot_req, draw, erase, paused, game_over, obj_sel, frames_done};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    // Reference model: which phase of the frame we are in, how many objects of the
    // current pass are plotted, how many unpaused WAIT cycles remain, frames so far.
    int m_ph = P_IDLE;
    int m_obj = 0;
    int m_wait_left = 0;
    int m_frames = 0;
    bit m_paused = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_ph = P_IDLE; m_obj = 0; m_frames = 0; m_paused = 1'b0; m_wait_left = 0;
        end else begin
            m_paused = (m_ph == P_WAIT) && pause;
            case (m_ph)
                P_IDLE: if (start) m_ph = P_ARM;
                P_ARM:  if (!start) m_ph = P_UPD;
                P_UPD:  m_ph = P_CHK;
                P_CHK:  m_ph = finish_game ? P_END : P_DRAW;
                P_DRAW: if (plot_done) begin
                    m_obj++;
                    if (m_obj == NUM_OBJ) begin
                        m_obj = 0; m_wait_left = FRAME_TICKS; m_ph = P_WAIT;
                    end
                end
                P_WAIT: if (!pause) begin
                    m_wait_left--;
                    if (m_wait_left == 0) m_ph = P_ERASE;
                end
                P_ERASE: if (plot_done) begin
                    m_obj++;
                    if (m_obj == NUM_OBJ) begin
                        m_obj = 0; m_frames++; m_ph = P_UPD;
                    end
                end
                P_END: if (start) begin m_frames = 0; m_ph = P_ARM; end
                default: m_ph = P_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        logic [9:0] exp_vec;
        if (chk_en) begin
            exp_vec = {m_ph == P_UPD, (m_ph == P_DRAW) || (m_ph == P_ERASE),
                       m_ph == P_DRAW, m_ph == P_ERASE, m_paused, m_ph == P_END,
                       2'(m_obj), 2'(m_frames % (1 << FCNT_W))};
            chk("cycle_outputs", 32'(out_vec), 32'(exp_vec));
        end
    end

    // Plotter: answers each request after a latency, one-cycle pulses only;
    // optionally emits stray pulses while nothing is requested.
    int pd_cnt = 0;
    int pd_lat = 3;
    always @(negedge clock) begin
        if (plot_done) begin
            plot_done = 1'b0;
            pd_cnt = 0;
            pd_lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5));
        end else if (plot_req) begin
            pd_cnt++;
            if (pd_cnt >= pd_lat) plot_done = 1'b1;
        end else begin
            pd_cnt = 0;
            if (stray_en && $urandom_range(0, 5) == 0) plot_done = 1'b1;
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Observe one frame from before DRAW until the next UPDATE pulse.
    task automatic watch_frame(input int pause_at, input bit pause_in_draw,
                               output string dseq, output string eseq,
                               output int gap, output int pcnt, output int fd);
        bit d_seen = 1'b0;
        bit e_seen = 1'b0;
        bit done = 1'b0;
        bit pdone = 1'b0;
        int last = -1;
        int left = 0;
        dseq = ""; eseq = ""; gap = 0; pcnt = 0; fd = -1;
        for (int c = 0; c < 400 && !done; c++) begin
            step();
            if (draw) begin
                if (int'(obj_sel) != last) begin
                    dseq = {dseq, $sformatf("%0d", obj_sel)};
                    last = int'(obj_sel);
                end
                d_seen = 1'b1;
                if (pause_in_draw) pause = 1'b1;
            end else if (erase) begin
                if (!e_seen) last = -1;
                e_seen = 1'b1;
                if (int'(obj_sel) != last) begin
                    eseq = {eseq, $sformatf("%0d", obj_sel)};
                    last = int'(obj_sel);
                end
            end else if (d_seen && !e_seen) begin
                gap++;
                if (pause_in_draw) pause = 1'b0;
                if (paused) pcnt++;
                if (left > 0) begin
                    left--;
                    if (left == 0) pause = 1'b0;
                end else if (!pdone && pause_at >= 0 && gap == pause_at + 1) begin
                    pause = 1'b1; left = 20; pdone = 1'b1;
                end
            end else if (e_seen && update) begin
                fd = int'(frames_done);
                done = 1'b1;
            end
        end
        chk("frame_completed", 32'(done), 32'd1);
    endtask

    initial begin
        string ds, es;
        int gap, pcnt, fd;
        bit found;
        int exp_fd[4] = '{2, 3, 0, 1};

        step(); step();
        chk("reset_outputs", 32'(out_vec), 32'd0);
        chk_en = 1'b1;
        reset = 1'b0;
        step();

        // start pulse: ARM then UPDATE for exactly one cycle
        start = 1'b1; step();
        chk("arm_no_update", 32'(update), 32'd0);
        start = 1'b0; step();
        chk("update_pulse", 32'(update), 32'd1);
        step();
        chk("update_one_cycle", 32'(update), 32'd0);

        // plain frame
        watch_frame(-1, 1'b0, ds, es, gap, pcnt, fd);
        chk_s("draw_seq_f1", ds, "0123");
        chk_s("erase_seq_f1", es, "0123");
        chk("wait_len_f1", 32'(gap), 32'd8);
        chk("paused_cnt_f1", 32'(pcnt), 32'd0);
        chk("frames_f1", 32'(fd), 32'd1);

        // pause from WAIT cycle 3 for 20 cycles
        watch_frame(3, 1'b0, ds, es, gap, pcnt, fd);
        chk_s("draw_seq_f2", ds, "0123");
        chk("wait_len_paused", 32'(gap), 32'd28);
        chk("paused_cnt", 32'(pcnt), 32'd20);
        chk("resume_to_erase", 32'(gap - 4 - 20), 32'd4);
        chk("frames_f2", 32'(fd), 32'd2);

        // game over in frame-3 CHECK, then restart
        finish_game = 1'b1; step();
        step();
        chk("game_over", 32'(game_over), 32'd1);
        chk("frames_at_end", 32'(frames_done), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_plot_in_end", 32'(plot_req), 32'd0);
        end
        finish_game = 1'b0;
        start = 1'b1; step();
        chk("restart_frames_clr", 32'(frames_done), 32'd0);
        chk("restart_not_over", 32'(game_over), 32'd0);
        start = 1'b0; step();
        chk("restart_update", 32'(update), 32'd1);

        // pause held during DRAW only has no effect
        watch_frame(-1, 1'b1, ds, es, gap, pcnt, fd);
        chk_s("draw_seq_pdraw", ds, "0123");
        chk("wait_len_pdraw", 32'(gap), 32'd8);
        chk("paused_cnt_pdraw", 32'(pcnt), 32'd0);
        chk("frames_wrap_1", 32'(fd), 32'd1);

        // wrap of the 2-bit frame counter with stray plotter pulses
        stray_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            watch_frame(-1, 1'b0, ds, es, gap, pcnt, fd);
            chk("frames_wrap", 32'(fd), 32'(exp_fd[f]));
            chk("wait_len_stray", 32'(gap), 32'd8);
        end
        stray_en = 1'b0;

        // reset mid-DRAW at obj 2 coinciding with plot_done
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            if (draw && obj_sel == 2'd2 && plot_done) found = 1'b1;
        end
        chk("found_obj2_done", 32'(found), 32'd1);
        reset = 1'b1; step();
        chk("reset_mid_draw", 32'(out_vec), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // randomized traffic checked cycle by cycle against the model
        lat_fixed = 0;
        stray_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            finish_game = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0; start = 1'b0; pause = 1'b0; finish_game = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
